// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and lock-state encoding, used by the
// timing controller and by the sync decoder.
package vga_timing_pkg;

    localparam int HPIXELS = 800;
    localparam int VLINES  = 521;
    localparam int HBP     = 144;
    localparam int HFP     = 784;
    localparam int VBP     = 31;
    localparam int VFP     = 511;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // 10-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3ff) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// VGA stream plus recovered-timing results exchanged between a video source
// (master) and the sync decoder (slave).
interface vga_sync_decoder_if;

    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    logic       locked;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_rgb;
    logic       frame_start;
    logic [9:0] hlen_meas;
    logic [9:0] vlen_meas;
    logic       err_hlen;
    logic       err_vlen;

    modport master (
        output pix_en, hsync, vsync, red, green, blue,
        input  locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start,
               hlen_meas, vlen_meas, err_hlen, err_vlen
    );

    modport slave (
        input  pix_en, hsync, vsync, red, green, blue,
        output locked, pix_valid, pix_x, pix_y, pix_rgb, frame_start,
               hlen_meas, vlen_meas, err_hlen, err_vlen
    );

endinterface

// File: rtl/vga_edge_det.sv
// Strobe-qualified falling-edge detector; the previous sample idles high so a
// line held low through reset is reported as an edge on the first strobe.
module vga_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic fall
);

    logic q;

    // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b1;
        else if (en)
            q <= d;
    end

    assign fall = en & q & ~d;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers line/frame position from a sampled VGA stream, verifies the timing
// against the nominal geometry and emits per-pixel coordinates once locked.
module vga_sync_decoder #(
    parameter int HPIXELS = vga_timing_pkg::HPIXELS,
    parameter int VLINES  = vga_timing_pkg::VLINES,
    parameter int HBP     = vga_timing_pkg::HBP,
    parameter int HFP     = vga_timing_pkg::HFP,
    parameter int VBP     = vga_timing_pkg::VBP,
    parameter int VFP     = vga_timing_pkg::VFP
) (
    input  logic              clk,
    input  logic              clr,
    vga_sync_decoder_if.slave bus
);

    import vga_timing_pkg::*;

    logic        h_fall;
    logic        v_fall;
    logic [9:0]  hc;
    logic [9:0]  vc;
    lock_state_t state;

    logic [9:0]  hc_next;
    logic [9:0]  vc_next;
    logic [9:0]  hlen_new;
    logic [9:0]  vlen_new;
    lock_state_t state_next;
    logic        h_bad;
    logic        v_bad;
    logic        checking;
    logic        visible;

    vga_edge_det u_hs_det (
        .clk  (clk),
        .clr  (clr),
        .en   (bus.pix_en),
        .d    (bus.hsync),
        .fall (h_fall)
    );

    vga_edge_det u_vs_det (
        .clk  (clk),
        .clr  (clr),
        .en   (bus.pix_en),
        .d    (bus.vsync),
        .fall (v_fall)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        hc_next    = hc;
        vc_next    = vc;
        state_next = state;
        hlen_new   = sat_inc(hc);
        vlen_new   = sat_inc(vc);
        h_bad      = h_fall && (hlen_new != 10'(HPIXELS));
        v_bad      = v_fall && (vlen_new != 10'(VLINES));
        checking   = (state != SEARCH);

        if (bus.pix_en) begin
            hc_next = h_fall ? 10'd0 : sat_inc(hc);
            // A frame edge wins over the line edge it usually coincides with.
            if (v_fall)
                vc_next = 10'd0;
            else if (h_fall)
                vc_next = sat_inc(vc);

            case (state)
                SEARCH:  if (v_fall) state_next = LOCKING;
                LOCKING: begin
                    if (h_bad || v_bad)
                        state_next = SEARCH;
                    else if (v_fall)
                        state_next = LOCKED;
                end
                LOCKED:  if (h_bad || v_bad) state_next = SEARCH;
                default: state_next = SEARCH;
            endcase
        end

        // Qualified on the post-update lock state so a losing edge shows no pixel.
        visible = (state_next == LOCKED)
               && (hc_next >= 10'(HBP)) && (hc_next < 10'(HFP))
               && (vc_next >= 10'(VBP)) && (vc_next < 10'(VFP));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hc              <= 10'd0;
            vc              <= 10'd0;
            state           <= SEARCH;
            bus.locked      <= 1'b0;
            bus.pix_valid   <= 1'b0;
            bus.pix_x       <= 10'd0;
            bus.pix_y       <= 10'd0;
            bus.pix_rgb     <= 8'd0;
            bus.frame_start <= 1'b0;
            bus.hlen_meas   <= 10'd0;
            bus.vlen_meas   <= 10'd0;
            bus.err_hlen    <= 1'b0;
            bus.err_vlen    <= 1'b0;
        end else begin
            bus.pix_valid   <= 1'b0;
            bus.frame_start <= 1'b0;

            if (bus.pix_en) begin
                hc              <= hc_next;
                vc              <= vc_next;
                state           <= state_next;
                bus.locked      <= (state_next == LOCKED);
                bus.frame_start <= v_fall;

                if (h_fall)
                    bus.hlen_meas <= hlen_new;
                if (v_fall)
                    bus.vlen_meas <= vlen_new;

                if (checking && h_bad)
                    bus.err_hlen <= 1'b1;
                if (checking && v_bad)
                    bus.err_vlen <= 1'b1;

                if (visible) begin
                    bus.pix_valid <= 1'b1;
                    bus.pix_x     <= hc_next - 10'(HBP);
                    bus.pix_y     <= vc_next - 10'(VBP);
                    bus.pix_rgb   <= {bus.red, bus.green, bus.blue};
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced geometry; a line/frame
// level model pushes expected pixels and lock/frame events, a monitor pops them.
module tb_vga_sync_decoder;

    localparam int HP  = 40;
    localparam int VL  = 12;
    localparam int HB  = 8;
    localparam int HF  = 36;
    localparam int VB  = 3;
    localparam int VF  = 10;
    localparam int HSW = 4;
    localparam int VSW = 2;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .HPIXELS (HP),
        .VLINES  (VL),
        .HBP     (HB),
        .HFP     (HF),
        .VBP     (VB),
        .VFP     (VF)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    typedef struct { int x; int y; int rgb; } pix_t;
    typedef struct { int lck; int hlen; int vlen; int eh; int ev; } stat_t;

    pix_t  pix_q[$];
    stat_t lock_q[$];
    stat_t fs_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: line/frame level view of the stream.
    int m_state   = 0;   // 0 searching, 1 locking, 2 locked
    int m_vcnt    = 0;   // lines seen since the last frame edge
    int m_hlen    = 0;   // expected hlen_meas, -1 when unknowable
    int m_vlen    = 0;
    int m_cur_len = -1;  // length of the line in progress, -1 if it began before a reset
    int m_eh      = 0;
    int m_ev      = 0;
    bit m_prev_v  = 1'b1;

    logic mon_en      = 1'b0;
    logic prev_locked = 1'b0;
    int   pix_seen    = 0;
    int   snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with no expected entry", name);
    endtask

    task automatic check_stat(input string tag, input stat_t s);
        check({tag, " locked"}, 32'(bus.locked), s.lck);
        if (s.hlen >= 0)
            check({tag, " hlen_meas"}, 32'(bus.hlen_meas), s.hlen);
        check({tag, " vlen_meas"}, 32'(bus.vlen_meas), s.vlen);
        check({tag, " err_hlen"}, 32'(bus.err_hlen), s.eh);
        check({tag, " err_vlen"}, 32'(bus.err_vlen), s.ev);
    endtask

    task automatic check_reset();
        check("rst locked",      32'(bus.locked),      0);
        check("rst pix_valid",   32'(bus.pix_valid),   0);
        check("rst pix_x",       32'(bus.pix_x),       0);
        check("rst pix_y",       32'(bus.pix_y),       0);
        check("rst pix_rgb",     32'(bus.pix_rgb),     0);
        check("rst frame_start", 32'(bus.frame_start), 0);
        check("rst hlen_meas",   32'(bus.hlen_meas),   0);
        check("rst vlen_meas",   32'(bus.vlen_meas),   0);
        check("rst err_hlen",    32'(bus.err_hlen),    0);
        check("rst err_vlen",    32'(bus.err_vlen),    0);
    endtask

    function automatic int sat10(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        pix_t  e;
        stat_t s;
        if (mon_en) begin
            if (bus.pix_valid === 1'b1) begin
                pix_seen <= pix_seen + 1;
                if (pix_q.size() == 0)
                    unexpected("pix_valid");
                else begin
                    e = pix_q.pop_front();
                    check("pix_x",   32'(bus.pix_x),   e.x);
                    check("pix_y",   32'(bus.pix_y),   e.y);
                    check("pix_rgb", 32'(bus.pix_rgb), e.rgb);
                end
            end
            if (bus.frame_start === 1'b1) begin
                if (fs_q.size() == 0)
                    unexpected("frame_start");
                else begin
                    s = fs_q.pop_front();
                    check_stat("frame_start", s);
                end
            end
            if (bus.locked !== prev_locked) begin
                if (lock_q.size() == 0)
                    unexpected("locked change");
                else begin
                    s = lock_q.pop_front();
                    check_stat("lock change", s);
                end
            end
            prev_locked <= bus.locked;
        end
    end

    task automatic model_line_start(input int len, input bit vflag);
        bit    vf;
        bit    hb;
        bit    vb;
        int    old_lck;
        stat_t s;
        vf       = vflag && !m_prev_v;
        m_prev_v = vflag;
        old_lck  = (m_state == 2) ? 1 : 0;
        m_hlen    = (m_cur_len < 0) ? -1 : sat10(m_cur_len);
        m_cur_len = len;
        if (vf) begin
            m_vlen = sat10(m_vcnt + 1);
            m_vcnt = 0;
        end else begin
            m_vcnt = sat10(m_vcnt + 1);
        end
        hb = (m_hlen != HP);
        vb = vf && (m_vlen != VL);
        if (m_state == 0) begin
            if (vf) m_state = 1;
        end else if (hb || vb) begin
            if (hb) m_eh = 1;
            if (vb) m_ev = 1;
            m_state = 0;
        end else if (vf && m_state == 1) begin
            m_state = 2;
        end
        s = '{(m_state == 2) ? 1 : 0, m_hlen, m_vlen, m_eh, m_ev};
        if (vf)
            fs_q.push_back(s);
        if (s.lck != old_lck)
            lock_q.push_back(s);
    endtask

    task automatic strobe(input logic hs, input logic vs, input logic [7:0] rgb);
        @(negedge clk);
        bus.pix_en = 1'b1;
        bus.hsync  = hs;
        bus.vsync  = vs;
        bus.red    = rgb[7:5];
        bus.green  = rgb[4:2];
        bus.blue   = rgb[1:0];
        @(negedge clk);
        bus.pix_en = 1'b0;
    endtask

    task automatic do_clr();
        stat_t s;
        if (m_state == 2) begin
            s = '{0, 0, 0, 0, 0};
            lock_q.push_back(s);
        end
        m_state   = 0;
        m_vcnt    = 0;
        m_hlen    = 0;
        m_vlen    = 0;
        m_cur_len = -1;
        m_eh      = 0;
        m_ev      = 0;
        m_prev_v  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_reset();
    endtask

    task automatic drive_line(input int len, input bit vflag, input int clr_at);
        logic [7:0] rgb;
        int         hc;
        pix_t       p;
        for (int i = 0; i < len; i++) begin
            if (i == 0)
                model_line_start(len, vflag);
            rgb = 8'($urandom_range(0, 255));
            hc  = sat10(i);
            if (m_state == 2 && hc >= HB && hc < HF && m_vcnt >= VB && m_vcnt < VF) begin
                p = '{hc - HB, m_vcnt - VB, int'(rgb)};
                pix_q.push_back(p);
            end
            strobe(logic'(i >= HSW), logic'(!vflag), rgb);
            if (i == clr_at)
                do_clr();
        end
    endtask

    task automatic drive_frame(input int nlines, input int mod_line, input int mod_len,
                               input int clr_line, input int clr_at);
        for (int l = 0; l < nlines; l++)
            drive_line((l == mod_line) ? mod_len : HP, bit'(l < VSW),
                       (l == clr_line) ? clr_at : -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pix_en = 1'b0;
        bus.hsync  = 1'b1;
        bus.vsync  = 1'b1;
        bus.red    = 3'd0;
        bus.green  = 3'd0;
        bus.blue   = 2'd0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check_reset();
        mon_en = 1'b1;

        // Partial pre-roll, then two frames to reach lock.
        repeat (5) drive_line(HP, 1'b0, -1);
        drive_frame(VL, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, -1, 0);
        check("locked after 2nd frame_start", 32'(bus.locked), 1);

        snap = pix_seen;
        drive_frame(VL, -1, 0, -1, 0);
        check("pixels per locked frame", 32'(pix_seen - snap), (HF - HB) * (VF - VB));

        // hsync held high long enough to saturate the line counter.
        drive_frame(VL, 4, HSW + 1100, -1, 0);
        check("err_hlen after stuck hsync", 32'(bus.err_hlen), 1);
        check("locked after stuck hsync", 32'(bus.locked), 0);
        drive_frame(VL, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, 5, 20);
        drive_frame(VL, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, -1, 0);
        check("relocked after clr", 32'(bus.locked), 1);
        check("err_hlen cleared by clr", 32'(bus.err_hlen), 0);

        // One short line while locked.
        drive_frame(VL, 5, HP - 1, -1, 0);
        check("locked after short line", 32'(bus.locked), 0);
        drive_frame(VL, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, -1, 0);
        check("relocked after short line", 32'(bus.locked), 1);
        check("err_hlen sticky", 32'(bus.err_hlen), 1);

        // One frame a line short while locked.
        drive_frame(VL - 1, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, -1, 0);
        check("vlen_meas after short frame", 32'(bus.vlen_meas), VL - 1);
        check("err_vlen after short frame", 32'(bus.err_vlen), 1);
        check("locked after short frame", 32'(bus.locked), 0);
        drive_frame(VL, -1, 0, -1, 0);
        drive_frame(VL, -1, 0, -1, 0);
        check("relocked after short frame", 32'(bus.locked), 1);

        repeat (4) @(negedge clk);
        check("pixel queue drained", 32'(pix_q.size()), 0);
        check("lock queue drained", 32'(lock_q.size()), 0);
        check("frame queue drained", 32'(fs_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
